// File: rtl/uart_rx_ctrl.sv
// Register-port controller for the UART receiver: holds its configuration,
// sequences receiver resets, and buffers completed frames in an RX FIFO.
module uart_rx_ctrl #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [23:0] BAUD_RST   = 24'd867
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        bus_we,
  input  logic        bus_re,
  input  logic [1:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        dec_nrst,
  output logic [23:0] dec_baudcontrol,
  output logic [1:0]  dec_parity,
  output logic        dec_stop_sel,
  input  logic        dec_rddone,
  input  logic        dec_perr,
  input  logic [7:0]  dec_data,
  output logic        irq
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 9;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DATA   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_THRESH = 2'd3;

  logic [23:0]   baud_q,      baud_d;
  logic [1:0]    parity_q,    parity_d;
  logic          stop_sel_q,  stop_sel_d;
  logic          rx_en_q,     rx_en_d;
  logic          irq_en_q,    irq_en_d;
  logic [7:0]    thresh_q,    thresh_d;
  logic [1:0]    hold_q,      hold_d;
  logic          rddone_q;
  logic [AW-1:0] wptr_q,      wptr_d;
  logic [AW-1:0] rptr_q,      rptr_d;
  logic [CW-1:0] count_q,     count_d;
  logic          overrun_q,   overrun_d;
  logic          perr_seen_q, perr_seen_d;
  logic [31:0]   rdata_q,     rdata_d;
  logic          irq_q,       irq_d;

  logic [EW-1:0] mem [FIFO_DEPTH];

  logic          wr_ctrl, wr_status, wr_thresh;
  logic          push, pop, push_ok, pop_ok;
  logic          fifo_full, fifo_empty;
  logic [EW-1:0] head;
  logic [7:0]    thr_eff;
  logic          unused_wdata;

  assign unused_wdata = ^bus_wdata[31:29];

  // Next-state for configuration, FIFO, status and read-back registers.
  always_comb begin
    baud_d      = baud_q;
    parity_d    = parity_q;
    stop_sel_d  = stop_sel_q;
    rx_en_d     = rx_en_q;
    irq_en_d    = irq_en_q;
    thresh_d    = thresh_q;
    hold_d      = (hold_q != 2'd0) ? hold_q - 2'd1 : 2'd0;
    rdata_d     = rdata_q;

    wr_ctrl    = bus_we && (bus_addr == ADDR_CTRL);
    wr_status  = bus_we && (bus_addr == ADDR_STATUS);
    wr_thresh  = bus_we && (bus_addr == ADDR_THRESH);

    fifo_full  = (count_q == CW'(FIFO_DEPTH));
    fifo_empty = (count_q == CW'(0));
    head       = mem[rptr_q];

    push    = dec_rddone && !rddone_q && rx_en_q;
    pop     = bus_re && (bus_addr == ADDR_DATA);
    pop_ok  = pop && !fifo_empty;
    // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
    push_ok = push && (!fifo_full || pop_ok);

    wptr_d  = push_ok ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop_ok  ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);

    // Set events win over a same-cycle write-1-clear.
    overrun_d   = (overrun_q   && !(wr_status && bus_wdata[18])) || (push && !push_ok);
    perr_seen_d = (perr_seen_q && !(wr_status && bus_wdata[19])) || (push && dec_perr);

    if (wr_ctrl) begin
      baud_d     = bus_wdata[23:0];
      parity_d   = bus_wdata[25:24];
      stop_sel_d = bus_wdata[26];
      rx_en_d    = bus_wdata[27];
      irq_en_d   = bus_wdata[28];
      hold_d     = 2'd2;
    end
    if (wr_thresh) begin
      thresh_d = bus_wdata[7:0];
    end

    if (bus_re) begin
      unique case (bus_addr)
        ADDR_CTRL:   rdata_d = {3'd0, irq_en_q, rx_en_q, stop_sel_q, parity_q, baud_q};
        ADDR_DATA:   rdata_d = pop_ok ? {22'd0, head[8], 1'b1, head[7:0]} : 32'd0;
        ADDR_STATUS: rdata_d = {12'd0, perr_seen_q, overrun_q, fifo_full, fifo_empty,
                                7'd0, 9'(count_q)};
        ADDR_THRESH: rdata_d = {24'd0, thresh_q};
        default:     rdata_d = 32'd0;
      endcase
    end

    thr_eff = (thresh_q == 8'd0) ? 8'd1 : thresh_q;
    irq_d   = irq_en_q && ((9'(count_q) >= {1'b0, thr_eff}) || overrun_q);
  end

  // State registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      baud_q      <= BAUD_RST;
      parity_q    <= 2'd0;
      stop_sel_q  <= 1'b0;
      rx_en_q     <= 1'b0;
      irq_en_q    <= 1'b0;
      thresh_q    <= 8'd1;
      hold_q      <= 2'd0;
      rddone_q    <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      perr_seen_q <= 1'b0;
      rdata_q     <= 32'd0;
      irq_q       <= 1'b0;
    end else begin
      baud_q      <= baud_d;
      parity_q    <= parity_d;
      stop_sel_q  <= stop_sel_d;
      rx_en_q     <= rx_en_d;
      irq_en_q    <= irq_en_d;
      thresh_q    <= thresh_d;
      hold_q      <= hold_d;
      rddone_q    <= dec_rddone;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      perr_seen_q <= perr_seen_d;
      rdata_q     <= rdata_d;
      irq_q       <= irq_d;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (nrst && push_ok) begin
      mem[wptr_q] <= {dec_perr, dec_data};
    end
  end

  assign bus_rdata       = rdata_q;
  assign irq             = irq_q;
  assign dec_baudcontrol = baud_q;
  assign dec_parity      = parity_q;
  assign dec_stop_sel    = stop_sel_q;
  // Receiver is held in reset while disabled and for two cycles after any CTRL write.
  assign dec_nrst        = nrst && rx_en_q && (hold_q == 2'd0);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl using a queue-based reference model.
module tb_uart_rx_ctrl;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        bus_we = 1'b0;
  logic        bus_re = 1'b0;
  logic [1:0]  bus_addr = 2'd0;
  logic [31:0] bus_wdata = 32'd0;
  logic [31:0] bus_rdata;
  logic        dec_nrst;
  logic [23:0] dec_baudcontrol;
  logic [1:0]  dec_parity;
  logic        dec_stop_sel;
  logic        dec_rddone = 1'b0;
  logic        dec_perr = 1'b0;
  logic [7:0]  dec_data = 8'd0;
  logic        irq;

  uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .BAUD_RST(24'd867)) dut (
    .clk(clk), .nrst(nrst), .bus_we(bus_we), .bus_re(bus_re), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .dec_nrst(dec_nrst),
    .dec_baudcontrol(dec_baudcontrol), .dec_parity(dec_parity), .dec_stop_sel(dec_stop_sel),
    .dec_rddone(dec_rddone), .dec_perr(dec_perr), .dec_data(dec_data), .irq(irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [8:0] mq[$];
  bit m_ovr, m_perr, m_rx_en, m_irq_en;
  int m_thr;

  function automatic void model_reset();
    mq.delete();
    m_ovr = 0; m_perr = 0; m_rx_en = 0; m_irq_en = 0; m_thr = 1;
  endfunction

  function automatic void model_push(input logic [7:0] d, input bit p);
    if (!m_rx_en) return;
    if (p) m_perr = 1;
    if (mq.size() == DEPTH) m_ovr = 1;
    else mq.push_back({p, d});
  endfunction

  function automatic logic [31:0] model_pop();
    logic [8:0] e;
    if (mq.size() == 0) return 32'd0;
    e = mq.pop_front();
    return {22'd0, e[8], 1'b1, e[7:0]};
  endfunction

  function automatic logic [31:0] model_status();
    int n;
    n = mq.size();
    return {12'd0, m_perr, m_ovr, (n == DEPTH), (n == 0), 7'd0, 9'(n)};
  endfunction

  function automatic logic model_irq();
    int t;
    t = (m_thr == 0) ? 1 : m_thr;
    return m_irq_en && ((mq.size() >= t) || m_ovr);
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_we = 1'b0;
    case (a)
      2'd0: begin m_rx_en = d[27]; m_irq_en = d[28]; end
      2'd2: begin if (d[18]) m_ovr = 0; if (d[19]) m_perr = 0; end
      2'd3: m_thr = int'(d[7:0]);
      default: ;
    endcase
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_re = 1'b1; bus_addr = a;
    @(negedge clk);
    bus_re = 1'b0;
    d = bus_rdata;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit p, input int hold);
    @(negedge clk);
    dec_data = d; dec_perr = p; dec_rddone = 1'b1;
    repeat (hold) @(negedge clk);
    dec_rddone = 1'b0; dec_perr = 1'b0;
    @(negedge clk);
    model_push(d, p);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    model_reset();
    total++; if (bus_rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", bus_rdata); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    total++; if (dec_nrst !== 1'b0) begin bad++; $display("FAIL reset_dec_nrst got=%b exp=0", dec_nrst); end
    total++; if ({dec_baudcontrol, dec_parity, dec_stop_sel} !== {24'd867, 2'd0, 1'b0}) begin
      bad++; $display("FAIL reset_dec_cfg got=%h/%h/%b", dec_baudcontrol, dec_parity, dec_stop_sel);
    end
    bus_read(2'd0, rd);
    total++; if (rd !== 32'h0000_0363) begin bad++; $display("FAIL reset_ctrl got=%h exp=00000363", rd); end
    bus_read(2'd3, rd);
    total++; if (rd !== 32'd1) begin bad++; $display("FAIL reset_thresh got=%h exp=1", rd); end
    bus_read(2'd2, rd);
    total++; if (rd !== 32'h0001_0000) begin bad++; $display("FAIL reset_status got=%h exp=00010000", rd); end
    bus_read(2'd1, rd);
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL reset_data_empty got=%h exp=0", rd); end
  endtask

  task automatic test_basic();
    logic [31:0] rd, ex;
    bus_write(2'd0, 32'h0800_0363);
    repeat (3) @(negedge clk);
    total++; if (dec_nrst !== 1'b1) begin bad++; $display("FAIL basic_dec_nrst got=%b exp=1", dec_nrst); end
    send_frame(8'h5A, 1'b0, $urandom_range(5, 40));
    bus_read(2'd2, rd);
    total++; if (rd !== model_status()) begin bad++; $display("FAIL basic_status1 got=%h exp=%h", rd, model_status()); end
    bus_read(2'd1, rd);
    ex = model_pop();
    total++; if (rd !== 32'h0000_015A || rd !== ex) begin bad++; $display("FAIL basic_data got=%h exp=0000015a", rd); end
    bus_read(2'd2, rd);
    total++; if (rd !== 32'h0001_0000) begin bad++; $display("FAIL basic_status0 got=%h exp=00010000", rd); end
  endtask

  task automatic test_perr_long();
    logic [31:0] rd, ex;
    bus_write(2'd0, 32'h0D00_0363);
    repeat (3) @(negedge clk);
    total++; if (dec_parity !== 2'b01 || dec_stop_sel !== 1'b1) begin
      bad++; $display("FAIL perr_cfg got=%b/%b exp=01/1", dec_parity, dec_stop_sel);
    end
    send_frame(8'h01, 1'b1, 1700);
    bus_read(2'd2, rd);
    total++; if (rd !== 32'h0008_0001) begin bad++; $display("FAIL perr_status got=%h exp=00080001", rd); end
    bus_read(2'd1, rd);
    ex = model_pop();
    total++; if (rd !== 32'h0000_0301 || rd !== ex) begin bad++; $display("FAIL perr_data got=%h exp=00000301", rd); end
    bus_write(2'd2, 32'h0008_0000);
    bus_read(2'd2, rd);
    total++; if (rd !== model_status()) begin bad++; $display("FAIL perr_w1c got=%h exp=%h", rd, model_status()); end
  endtask

  task automatic test_overrun();
    logic [31:0] rd, ex;
    bus_write(2'd0, 32'h1800_0363);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 9; i++) send_frame(8'(i + 1), 1'b0, $urandom_range(2, 30));
    bus_read(2'd2, rd);
    total++; if (rd !== 32'h0006_0008 || rd !== model_status()) begin
      bad++; $display("FAIL ovr_status got=%h exp=00060008", rd);
    end
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL ovr_irq got=%b exp=1", irq); end
    for (int i = 0; i < 8; i++) begin
      bus_read(2'd1, rd);
      ex = model_pop();
      total++; if (rd !== ex || rd[7:0] !== 8'(i + 1)) begin bad++; $display("FAIL ovr_data%0d got=%h exp=%h", i, rd, ex); end
    end
    bus_write(2'd2, 32'h0004_0000);
    bus_read(2'd2, rd);
    total++; if (rd !== 32'h0001_0000) begin bad++; $display("FAIL ovr_w1c got=%h exp=00010000", rd); end
    repeat (2) @(negedge clk);
    total++; if (irq !== model_irq()) begin bad++; $display("FAIL ovr_irq_clr got=%b exp=%b", irq, model_irq()); end
  endtask

  // Raises dec_rddone and a DATA read on the same clock edge.
  task automatic push_pop(input logic [7:0] d, output logic [31:0] rd, output logic [31:0] ex);
    @(negedge clk);
    dec_data = d; dec_perr = 1'b0; dec_rddone = 1'b1;
    bus_re = 1'b1; bus_addr = 2'd1;
    @(negedge clk);
    bus_re = 1'b0;
    rd = bus_rdata;
    ex = model_pop();
    model_push(d, 1'b0);
    repeat (3) @(negedge clk);
    dec_rddone = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_same_cycle();
    logic [31:0] rd, ex;
    for (int i = 0; i < 8; i++) send_frame(8'($urandom), 1'b0, $urandom_range(1, 10));
    push_pop(8'($urandom), rd, ex);
    total++; if (rd !== ex) begin bad++; $display("FAIL sc_full_data got=%h exp=%h", rd, ex); end
    bus_read(2'd2, rd);
    total++; if (rd !== 32'h0002_0008 || rd !== model_status()) begin bad++; $display("FAIL sc_full_status got=%h exp=00020008", rd); end
    for (int i = 0; i < 8; i++) begin
      bus_read(2'd1, rd);
      ex = model_pop();
      total++; if (rd !== ex) begin bad++; $display("FAIL sc_drain%0d got=%h exp=%h", i, rd, ex); end
    end
    push_pop(8'hC3, rd, ex);
    total++; if (rd !== 32'd0 || rd !== ex) begin bad++; $display("FAIL sc_empty_data got=%h exp=0", rd); end
    bus_read(2'd2, rd);
    total++; if (rd !== 32'h0000_0001) begin bad++; $display("FAIL sc_empty_status got=%h exp=00000001", rd); end
    bus_read(2'd1, rd);
    ex = model_pop();
    total++; if (rd !== 32'h0000_01C3 || rd !== ex) begin bad++; $display("FAIL sc_empty_byte got=%h exp=000001c3", rd); end
  endtask

  task automatic test_ctrl_abort();
    logic [31:0] rd, ex;
    total++; if (dec_nrst !== 1'b1) begin bad++; $display("FAIL abort_pre got=%b exp=1", dec_nrst); end
    // Receiver is mid-frame: dec_rddone never rises for the aborted frame.
    repeat ($urandom_range(5, 50)) @(negedge clk);
    bus_write(2'd0, 32'h1800_0363);
    total++; if (dec_nrst !== 1'b0) begin bad++; $display("FAIL abort_low1 got=%b exp=0", dec_nrst); end
    @(negedge clk);
    total++; if (dec_nrst !== 1'b0) begin bad++; $display("FAIL abort_low2 got=%b exp=0", dec_nrst); end
    @(negedge clk);
    total++; if (dec_nrst !== 1'b1) begin bad++; $display("FAIL abort_release got=%b exp=1", dec_nrst); end
    bus_read(2'd2, rd);
    total++; if (rd !== model_status()) begin bad++; $display("FAIL abort_nopush got=%h exp=%h", rd, model_status()); end
    send_frame(8'($urandom), 1'($urandom), $urandom_range(5, 40));
    bus_read(2'd1, rd);
    ex = model_pop();
    total++; if (rd !== ex) begin bad++; $display("FAIL abort_next got=%h exp=%h", rd, ex); end
    bus_write(2'd2, 32'h000C_0000);
  endtask

  task automatic test_thresh_irq();
    logic [31:0] rd, ex;
    bus_write(2'd3, 32'd3);
    send_frame(8'h11, 1'b0, 4);
    send_frame(8'h22, 1'b0, 4);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL thr_below got=%b exp=0", irq); end
    @(negedge clk);
    dec_data = 8'h33; dec_rddone = 1'b1;
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL thr_push_cycle got=%b exp=0", irq); end
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL thr_rise got=%b exp=1", irq); end
    dec_rddone = 1'b0;
    @(negedge clk);
    model_push(8'h33, 1'b0);
    bus_read(2'd1, rd);
    ex = model_pop();
    total++; if (rd !== ex) begin bad++; $display("FAIL thr_pop_data got=%h exp=%h", rd, ex); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL thr_pop_cycle got=%b exp=1", irq); end
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL thr_fall got=%b exp=0", irq); end
    bus_write(2'd3, 32'd0);
    repeat (2) @(negedge clk);
    total++; if (irq !== 1'b1 || model_irq() !== 1'b1) begin bad++; $display("FAIL thr_zero got=%b exp=1", irq); end
    for (int i = 0; i < 2; i++) begin
      bus_read(2'd1, rd);
      ex = model_pop();
      total++; if (rd !== ex) begin bad++; $display("FAIL thr_drain%0d got=%h exp=%h", i, rd, ex); end
    end
  endtask

  task automatic test_rx_disable();
    logic [31:0] rd;
    send_frame(8'hA5, 1'b0, 6);
    bus_write(2'd0, 32'h0000_0363);
    @(negedge clk);
    total++; if (dec_nrst !== 1'b0) begin bad++; $display("FAIL dis_dec_nrst got=%b exp=0", dec_nrst); end
    send_frame(8'h5A, 1'b1, 6);
    bus_read(2'd2, rd);
    total++; if (rd !== 32'h0000_0001 || rd !== model_status()) begin bad++; $display("FAIL dis_status got=%h exp=00000001", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, ex, cfg;
    cfg = {3'd0, 1'b1, 1'b1, 1'($urandom), 2'($urandom), 24'($urandom)};
    bus_write(2'd0, cfg);
    bus_write(2'd3, 32'($urandom_range(0, 9)));
    repeat (3) @(negedge clk);
    total++; if ({dec_baudcontrol, dec_parity, dec_stop_sel} !== {cfg[23:0], cfg[25:24], cfg[26]}) begin
      bad++; $display("FAIL rnd_cfg got=%h/%h/%b exp=%h", dec_baudcontrol, dec_parity, dec_stop_sel, cfg);
    end
    bus_read(2'd0, rd);
    total++; if (rd !== cfg) begin bad++; $display("FAIL rnd_ctrl_rd got=%h exp=%h", rd, cfg); end
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: send_frame(8'($urandom), 1'($urandom_range(0, 3) == 0), $urandom_range(1, 25));
        3: begin
          bus_read(2'd1, rd);
          ex = model_pop();
          total++; if (rd !== ex) begin bad++; $display("FAIL rnd_data%0d got=%h exp=%h", i, rd, ex); end
        end
        4: begin
          bus_read(2'd2, rd);
          total++; if (rd !== model_status()) begin bad++; $display("FAIL rnd_status%0d got=%h exp=%h", i, rd, model_status()); end
        end
        default: bus_write(2'd2, {12'd0, 2'($urandom), 18'($urandom)});
      endcase
      @(negedge clk);
      total++; if (irq !== model_irq()) begin bad++; $display("FAIL rnd_irq%0d got=%b exp=%b", i, irq, model_irq()); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    send_frame(8'h77, 1'b1, 3);
    @(negedge clk);
    dec_rddone = 1'b1; dec_data = 8'h66; bus_re = 1'b1; bus_addr = 2'd1; nrst = 1'b0;
    @(negedge clk);
    dec_rddone = 1'b0; bus_re = 1'b0; nrst = 1'b1;
    model_reset();
    total++; if (bus_rdata !== 32'd0 || irq !== 1'b0 || dec_nrst !== 1'b0) begin
      bad++; $display("FAIL rstmid_outs got=%h/%b/%b exp=0/0/0", bus_rdata, irq, dec_nrst);
    end
    bus_read(2'd2, rd);
    total++; if (rd !== 32'h0001_0000) begin bad++; $display("FAIL rstmid_status got=%h exp=00010000", rd); end
    bus_read(2'd0, rd);
    total++; if (rd !== 32'h0000_0363) begin bad++; $display("FAIL rstmid_ctrl got=%h exp=00000363", rd); end
    bus_read(2'd3, rd);
    total++; if (rd !== 32'd1) begin bad++; $display("FAIL rstmid_thresh got=%h exp=1", rd); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_perr_long();
    test_overrun();
    test_same_cycle();
    test_ctrl_abort();
    test_thresh_irq();
    test_rx_disable();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Bus-facing controller for the UART receiver datapath.
- Holds the receiver configuration: baud divisor, parity mode, stop-bit select, enable.
- Sequences receiver resets on enable and config changes.
- Captures each completed frame into an RX FIFO with its parity-error tag.
- Exposes data, status and interrupt to the core through a simple register port.

Parameters:
FIFO_DEPTH, 8, RX FIFO entries; power of two, 2..256
BAUD_RST, 24'd867, reset value of baud divisor (Fclk/Fbaud - 1)

Ports:
clk  in  1  core clock
nrst  in  1  reset, synchronous, active-low
bus_we  in  1  register write strobe, one cycle
bus_re  in  1  register read strobe, one cycle
bus_addr  in  2  register word index
bus_wdata  in  32  write data
bus_rdata  out  32  read data, registered
dec_nrst  out  1  reset to receiver, active-low
dec_baudcontrol  out  24  baud divisor to receiver
dec_parity  out  2  parity mode to receiver (00/11 none, 01 even, 10 odd)
dec_stop_sel  out  1  stop-bit select to receiver (0 = 1 bit, 1 = 2 bits)
dec_rddone  in  1  receiver frame-done; level, high for up to a full stop-bit time
dec_perr  in  1  receiver parity error, valid while dec_rddone high
dec_data  in  8  received byte, valid while dec_rddone high
irq  out  1  level interrupt

Behaviour:
Register map (bus_addr):
- 0 CTRL, R/W: [23:0] baud, [25:24] parity, [26] stop_sel, [27] rx_en, [28] irq_en.
- 1 DATA, RO, pop on read: [7:0] byte, [8] valid, [9] perr tag, rest 0.
- 2 STATUS: [8:0] count, [16] empty, [17] full, [18] overrun (sticky, write-1-clear), [19] perr_seen (sticky, write-1-clear). All other bits RO.
- 3 THRESH, R/W: [7:0] irq level threshold.

Reset values:
- CTRL baud = BAUD_RST, parity = 00, stop_sel = 0, rx_en = 0, irq_en = 0.
- THRESH = 1.
- FIFO empty, overrun = 0, perr_seen = 0, bus_rdata = 0, irq = 0.

Receiver outputs:
- dec_baudcontrol, dec_parity and dec_stop_sel are driven directly from CTRL.

Receiver reset sequencing:
- dec_nrst = nrst & rx_en & ~cfg_hold.
- cfg_hold is set for exactly 2 cycles after any CTRL write, even if the value is unchanged. This aborts any in-flight frame so a frame is never decoded with mixed config.

Frame capture:
- Edge-detect dec_rddone with a registered copy (reset 0).
- On the 0->1 edge while rx_en = 1, push {dec_perr, dec_data}. Exactly one push per frame, regardless of the number of stop bits.
- If dec_perr = 1 on push, set perr_seen.

FIFO:
- Read/write pointers of log2(FIFO_DEPTH) bits wrap modulo depth; count is 0..FIFO_DEPTH.
- Push when full: byte dropped, overrun set, pointers unchanged.
- Pop (DATA read) when empty: returns valid = 0, byte 0, no pointer change.
- Push and pop in the same cycle: both take effect, count unchanged. If the FIFO was full, the push is accepted, with no overrun.
- If it was empty, the pop returns valid = 0 and the new byte stays in the FIFO.

Bus reads:
- bus_rdata is valid the cycle after bus_re (latency 1). It holds its value until the next read.
- A DATA read returns the head entry as it was before the pop.
- bus_we and bus_re in the same cycle are both serviced.

STATUS write-1-clear:
- A W1C write and a same-cycle set event on the same bit leave the bit set.

Interrupt:
- irq = irq_en & (count >= THRESH | overrun), registered one cycle.
- THRESH = 0 is treated as 1.

Other rules:
- rx_en = 0 holds the receiver in reset and suppresses pushes; FIFO contents are retained.
- nrst low mid-frame or mid-read returns all state to reset values on the next clock edge.

Test Plan:
- CTRL write 0x0800_0363 (rx_en, baud 867, no parity), send 0x5A -> one push; DATA read returns 0x0000_015A; STATUS count returns to 0.
- stop_sel = 1, even parity, byte 0x01 sent with wrong parity bit, dec_rddone high ~1700 cycles -> exactly one entry, DATA = 0x0000_0301, perr_seen = 1.
- 9 frames with depth 8 and no reads -> count = 8, full = 1, overrun = 1, irq = 1 when irq_en = 1. 8 DATA reads return bytes 1..8 in order. Write STATUS bit 18 -> overrun = 0.
- Push and DATA read in the same cycle, first at count 8, then at count 0 -> count stays 8 with no overrun; at empty the read returns valid = 0 and count becomes 1.
- CTRL write mid-frame -> dec_nrst low exactly 2 cycles, no push for the aborted frame; the next full frame is captured.
- THRESH = 3, irq_en = 1 -> irq rises the cycle after the 3rd push and falls the cycle after the pop that brings count to 2.
